// File: rtl/aes_pkg.sv
// Shared AES types plus byte S-box functions (GF(2^8) inverse followed by the AES affine map).
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [AES_STATE_W-1:0] aes_state_t;
  typedef logic [7:0]             aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sb_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic aes_byte_t gf_inv(input aes_byte_t a);
    aes_byte_t sq;
    aes_byte_t r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic aes_byte_t sbox_fwd(input aes_byte_t a);
    aes_byte_t x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_byte_t sbox_inv(input aes_byte_t b);
    aes_byte_t x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte-wide S-box lane; with SUBBYTES_INV_EN it carries both tables and a mode select.
module sbox_lane
  import aes_pkg::*;
(
`ifdef SUBBYTES_INV_EN
  input  logic       inv,
`endif
  input  logic [7:0] din,
  output logic [7:0] dout
);

`ifdef SUBBYTES_INV_EN
  assign dout = inv ? sbox_inv(din) : sbox_fwd(din);
`else
  assign dout = sbox_fwd(din);
`endif

endmodule

// File: rtl/subbytes_engine.sv
// Folded AES SubBytes: LANES bytes per beat through a rotating 128-bit register.
// Optional inverse mode is enabled by defining SUBBYTES_INV_EN.
module subbytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef SUBBYTES_INV_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int NBEATS = AES_BYTES / LANES;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_e         state_reg;
  sb_state_e         state_next;
  aes_state_t        work_reg;
  aes_state_t        work_next;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic [8*LANES-1:0] sub_bytes;
`ifdef SUBBYTES_INV_EN
  logic              mode_reg;
`endif

  // Lane 0 takes the most significant byte, so substituted bytes keep their relative order.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    sbox_lane u_lane (
`ifdef SUBBYTES_INV_EN
      .inv  (mode_reg),
`endif
      .din  (work_reg[AES_STATE_W-1-8*gi -: 8]),
      .dout (sub_bytes[8*LANES-1-8*gi -: 8])
    );
  end

  if (LANES == AES_BYTES) begin : g_rot_full
    assign work_next = sub_bytes;
  end else begin : g_rot_part
    assign work_next = {work_reg[AES_STATE_W-8*LANES-1:0], sub_bytes};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (beat_cnt_reg == LAST_BEAT) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      work_reg     <= '0;
      beat_cnt_reg <= '0;
`ifdef SUBBYTES_INV_EN
      mode_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg     <= in_data;
            beat_cnt_reg <= '0;
`ifdef SUBBYTES_INV_EN
            mode_reg     <= in_inv;
`endif
          end
        end
        BUSY: begin
          work_reg     <= work_next;
          beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = work_reg;

endmodule

// File: doc/subbytes_engine.md
# subbytes_engine

Folded, parametrised AES SubBytes engine for a full 128-bit state. Accepts one state over a valid/ready handshake, substitutes `LANES` bytes per clock through a bank of byte S-boxes, and presents the result over a valid/ready handshake. It sits between AddRoundKey and ShiftRows in the round datapath. `LANES` trades S-box area against latency. An optional inverse mode serves the decryption path.

## Interface
- `LANES`, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input state is valid.
- `in_ready` out 1: engine can accept a state.
- `in_data` in 128: state. Byte 0 is `[127:120]`, byte 15 is `[7:0]`.
- `in_inv` in 1: present only with `SUBBYTES_INV_EN`. 1 selects InvSubBytes.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 128: substituted state, in the same byte order as `in_data`.

## Operation
- Derived constant: `NBEATS = 16/LANES`.
- FSM states and transitions:
  - IDLE -> BUSY on `in_valid && in_ready`.
  - BUSY -> DONE after the `NBEATS`-th beat.
  - DONE -> IDLE on `out_valid && out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- Accept (IDLE):
  - `in_data` loads a 128-bit working register.
  - Beat counter clears to 0.
  - Mode bit latches from `in_inv` (or 0 without the macro).
- Each BUSY cycle:
  - The top `LANES` bytes (`[127 -: 8*LANES]`) pass through `LANES` S-box instances.
  - The register rotates left by `8*LANES` bits, and the substituted bytes enter at the bottom.
  - Beat counter increments.
  - After `NBEATS` beats, every byte has been substituted once and the original byte order is restored.
- `out_data` is the working register. It holds stable while in DONE; do not apply a combinational bypass.
- Input data and mode are sampled only at acceptance. Changes to `in_data` or `in_inv` during BUSY or DONE have no effect.
- Backpressure: DONE persists indefinitely while `out_ready` = 0. During that time `in_ready` stays 0.
- DONE with `out_valid && out_ready` and `in_valid` = 1 in the same cycle:
  - Output completes.
  - Input is not accepted, because `in_ready` = 0.
  - The input is accepted in the following IDLE cycle.
- Beat counter width is `$clog2(NBEATS)` with a minimum of 1 bit. When `LANES` = 16, BUSY lasts exactly one cycle.

## Timing
- Reset (`rst` high at an edge):
  - State goes to IDLE.
  - Working register, beat counter and mode bit go to 0.
  - `out_valid` = 0 and `out_data` = 0.
  - `in_ready` = 1 in the first cycle after `rst` deasserts.
- Reset mid-operation (BUSY or DONE) discards the state in flight. No `out_valid` pulse is emitted.
- Latency: handshake accepted at edge E0; beats occur at E1..E_NBEATS; `out_valid` is high in the cycle after E_NBEATS. That is `NBEATS+1` cycles from the accept cycle to the first `out_valid` cycle (5 for `LANES` = 4).
- Throughput: one state per `NBEATS+2` cycles when `out_ready` is held at 1.
- No combinational path from any input to any output, except `in_ready` and `out_valid`, which decode registered state only.

## Configuration
- `SUBBYTES_INV_EN` defined:
  - `in_inv` port exists.
  - Each lane instantiates forward and inverse S-box tables.
  - The latched mode bit selects the table per state.
- `SUBBYTES_INV_EN` undefined:
  - No `in_inv` port.
  - Forward S-box only.
  - Mode is tied to forward and the inverse tables are not synthesised.

## Structure
- Shared package `aes_pkg`:
  - `AES_STATE_W` = 128 and `AES_BYTES` = 16.
  - State and byte typedefs.
  - FSM state enum (IDLE, BUSY, DONE).
- One sub-module, `sbox_lane`: one byte in, one byte out, plus a mode input when `SUBBYTES_INV_EN` is defined. The engine instantiates `LANES` copies via generate.

## Test plan
- Reset, then `in_data` = 0, `LANES` = 4 -> `out_valid` rises exactly 5 cycles after accept, with `out_data` = `63636363_63636363_63636363_63636363`.
- `in_data` = `00112233_44556677_8899aabb_ccddeeff`, swept over `LANES` = 1/2/4/8/16 -> `out_data` = `638293c3_1bfc33f5_c4eeacea_4bc12816`, with latency 17/9/5/3/2.
- Hold `out_ready` = 0 for 10 cycles in DONE while `in_data` toggles:
  - `out_data` stays stable and `in_ready` stays 0.
  - The next state is accepted one cycle after the output handshake.
- Assert `rst` at beat 2 of a `LANES` = 4 run -> no `out_valid`, `in_ready` = 1 the next cycle, and the following state produces a correct result.
- With `SUBBYTES_INV_EN`:
  - `in_inv` = 1 and `in_data` = all `63` -> all `00`.
  - Back-to-back forward then inverse of the second vector returns `00112233_44556677_8899aabb_ccddeeff`.
